// File: rtl/cic_interpolator.sv
`timescale 1ns/1ps
// cic_interpolator
//   N-stage CIC interpolation filter with ratio R = 2**RLOG2.
//   Combs run once per input slot (phase 0). A zero-stuffer register
//   feeds the integrator chain, which runs at the full clk rate.
//   Optional build macro CIC_INT_HOLD_EN: when a phase-0 slot arrives
//   without a valid sample, the comb chain is fed the last accepted sample
//   instead of zero.
module cic_interpolator #(
  parameter  int N     = 3,
  parameter  int RLOG2 = 3,
  parameter  int IN_W  = 16,
  localparam int ACC_W = IN_W + (N - 1) * RLOG2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    underrun
);

  logic [RLOG2-1:0]        phase_r;
  logic                    fire_s;
  logic                    accept_s;
  logic                    starve_s;
  logic signed [ACC_W-1:0] sample_s;
  logic signed [ACC_W-1:0] x_s;
  logic signed [ACC_W-1:0] comb_in_s [N];
  logic signed [ACC_W-1:0] comb_acc_s;
  logic signed [ACC_W-1:0] delay_r   [N];
  logic signed [ACC_W-1:0] stuff_r;
  logic signed [ACC_W-1:0] integ_r   [N];
  logic signed [ACC_W-1:0] out_r;
  logic                    out_valid_r;
  logic                    underrun_r;

  // Slot decode: phase 0 is the single input slot of each R-cycle frame.
  assign fire_s   = (phase_r == {RLOG2{1'b0}});
  assign accept_s = fire_s & in_valid;
  assign starve_s = fire_s & ~in_valid;
  assign sample_s = ACC_W'(in_data);
  assign in_ready = fire_s;

  // Free-running phase counter; wraps naturally since R is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= {RLOG2{1'b0}};
    end else begin
      phase_r <= phase_r + RLOG2'(1);
    end
  end

`ifdef CIC_INT_HOLD_EN
  logic signed [ACC_W-1:0] last_r;

  // Remember the most recently accepted sample to fill starved slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= {ACC_W{1'b0}};
    end else if (accept_s) begin
      last_r <= sample_s;
    end else begin
      last_r <= last_r;
    end
  end

  // Comb input: fresh sample when valid, otherwise repeat the last one.
  always_comb begin
    x_s = {ACC_W{1'b0}};
    if (in_valid) begin
      x_s = sample_s;
    end else begin
      x_s = last_r;
    end
  end
`else
  // Comb input: fresh sample when valid, otherwise inject a zero sample.
  always_comb begin
    x_s = {ACC_W{1'b0}};
    if (in_valid) begin
      x_s = sample_s;
    end else begin
      x_s = {ACC_W{1'b0}};
    end
  end
`endif

  // Comb chain: each stage subtracts its own delayed input.
  always_comb begin
    comb_acc_s = x_s;
    for (int k = 0; k < N; k++) begin
      comb_in_s[k] = comb_acc_s;
      comb_acc_s   = comb_acc_s - delay_r[k];
    end
  end

  // Comb delay registers advance only in the input slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        delay_r[k] <= {ACC_W{1'b0}};
      end
    end else if (fire_s) begin
      for (int k = 0; k < N; k++) begin
        delay_r[k] <= comb_in_s[k];
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        delay_r[k] <= delay_r[k];
      end
    end
  end

  // Zero-stuffer: comb result in the input slot, zero in the other R-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuff_r <= {ACC_W{1'b0}};
    end else if (fire_s) begin
      stuff_r <= comb_acc_s;
    end else begin
      stuff_r <= {ACC_W{1'b0}};
    end
  end

  // Integrator chain at clk rate; each stage adds the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        integ_r[k] <= {ACC_W{1'b0}};
      end
    end else begin
      integ_r[0] <= integ_r[0] + stuff_r;
      for (int k = 1; k < N; k++) begin
        integ_r[k] <= integ_r[k] + integ_r[k-1];
      end
    end
  end

  // Output register and status flags (out_valid sticky after first accept).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      out_r       <= integ_r[N-1];
      out_valid_r <= out_valid_r | accept_s;
      underrun_r  <= starve_s;
    end
  end

  assign out_data  = out_r;
  assign out_valid = out_valid_r;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_cic_interpolator.sv
`timescale 1ns/1ps
// Directed bench for cic_interpolator: default instance (N=3, R=8) plus an
// R=4 instance for the impulse-response vector.
module tb_cic_interpolator;

  localparam int ACC_W  = 22;
  localparam int ACC4_W = 20;

  logic clk = 1'b0;
  logic rst_n;

  logic signed [15:0]       in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_valid;
  logic                     underrun;

  logic signed [15:0]       in_data4;
  logic                     in_valid4;
  logic                     in_ready4;
  logic signed [ACC4_W-1:0] out_data4;
  logic                     out_valid4;
  logic                     underrun4;

  int checks = 0;
  int errors = 0;
  int ph     = 0;

  // Boxcar^3 responses: length-4 boxes (R=4) and length-8 boxes (R=8).
  int imp4 [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
  int h8   [22] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48,
                    48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

  cic_interpolator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .underrun (underrun)
  );

  cic_interpolator #(.N(3), .RLOG2(2), .IN_W(16)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data4),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .out_data (out_data4),
    .out_valid(out_valid4),
    .underrun (underrun4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 8;
  endtask

  task automatic drive_tick(input int val, input bit valid);
    in_valid = valid;
    in_data  = (ph == 0) ? 16'(val) : 16'sh3039;
    tick();
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    in_data   = 16'sd0;
    in_data4  = 16'sd0;
    tick();
    tick();
    rst_n = 1'b1;
    ph    = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'sd0;
    in_valid4 = 1'b0; in_data4 = 16'sd0;
    #1;
    checks++; if (out_data !== 22'sd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    checks++; if (out_data4 !== 20'sd0) begin errors++; $display("FAIL reset_out_data4 got %0d want 0", out_data4); end
    tick();
    tick();
    rst_n = 1'b1;
    ph    = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (in_ready !== (ph == 0)) begin errors++; $display("FAIL ready_cadence cyc %0d got %b want %b", i, in_ready, (ph == 0)); end
      checks++; if (underrun !== (ph == 1)) begin errors++; $display("FAIL idle_underrun cyc %0d got %b want %b", i, underrun, (ph == 1)); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid cyc %0d got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_impulse();
    logic signed [ACC4_W-1:0] exp4;
    reset_dut();
    in_valid4 = 1'b1;
    in_data4  = 16'sd1;
    tick();
    in_data4 = 16'sd0;
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL impulse_out_valid got %b want 1", out_valid4); end
    for (int j = 1; j <= 17; j++) begin
      tick();
      if (j >= 4 && j < 14) exp4 = ACC4_W'(imp4[j-4]);
      else                  exp4 = '0;
      checks++; if (out_data4 !== exp4) begin errors++; $display("FAIL impulse edge+%0d got %0d want %0d", j, out_data4, exp4); end
    end
    in_valid4 = 1'b0;
  endtask

  task automatic test_dc();
    logic signed [ACC_W-1:0] exp;
    reset_dut();
    for (int j = 0; j < 54; j++) begin
      drive_tick(100, 1'b1);
      if (j == 0) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dc_out_valid got %b want 1", out_valid); end
      end
      if (j >= 4 && j <= 6) begin
        exp = ACC_W'(100 * h8[j-4]);
        checks++; if (out_data !== exp) begin errors++; $display("FAIL dc_rise edge+%0d got %0d want %0d", j, out_data, exp); end
      end
      if (j >= 30) begin
        checks++; if (out_data !== 22'sd6400) begin errors++; $display("FAIL dc_steady edge+%0d got %0d want 6400", j, out_data); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL dc_underrun edge+%0d got %b want 0", j, underrun); end
      end
    end
  endtask

  task automatic test_full_scale();
    reset_dut();
    for (int j = 0; j < 40; j++) drive_tick(-32768, 1'b1);
    for (int j = 0; j < 24; j++) begin
      drive_tick(-32768, 1'b1);
      checks++; if (out_data !== 22'sh200000) begin errors++; $display("FAIL full_scale cyc %0d got %0d want -2097152", j, out_data); end
    end
  endtask

  task automatic test_underrun();
    logic signed [ACC_W-1:0] exp;
    reset_dut();
    for (int j = 0; j < 40; j++) drive_tick(100, 1'b1);
    while (ph != 0) drive_tick(100, 1'b1);
    drive_tick(100, 1'b0);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse got %b want 1", underrun); end
    for (int k = 1; k <= 30; k++) begin
      drive_tick(100, 1'b1);
      if (k == 1) begin
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_width got %b want 0", underrun); end
      end
`ifdef CIC_INT_HOLD_EN
      exp = 22'sd6400;
`else
      if (k >= 4 && k <= 25) exp = ACC_W'(6400 - 100 * h8[k-4]);
      else                   exp = 22'sd6400;
`endif
      checks++; if (out_data !== exp) begin errors++; $display("FAIL underrun_resp edge+%0d got %0d want %0d", k, out_data, exp); end
    end
  endtask

  task automatic test_midrun_reset();
    reset_dut();
    for (int j = 0; j < 40; j++) drive_tick(100, 1'b1);
    checks++; if (out_data !== 22'sd6400) begin errors++; $display("FAIL midrun_pre got %0d want 6400", out_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_data !== 22'sd0) begin errors++; $display("FAIL midrun_out_data got %0d want 0", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_out_valid got %b want 0", out_valid); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midrun_underrun got %b want 0", underrun); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_in_ready got %b want 1", in_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    ph    = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_release_ready got %b want 1", in_ready); end
    for (int j = 0; j < 9; j++) begin
      drive_tick(100, 1'b1);
      checks++; if (in_ready !== (ph == 0)) begin errors++; $display("FAIL midrun_phase cyc %0d got %b want %b", j, in_ready, (ph == 0)); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrun_valid cyc %0d got %b want 1", j, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_full_scale();
    test_underrun();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
